shift_add_mult_ctrl: RTL and testbench

//   Control unit for the sequential shift-and-add multiplier datapath built from our
//   16-bit shift-register stages.
//   - Drives ld/shr_en of the multiplier (B) and product (P) registers.
//   - Consumes B's LSB_out to decide add vs. skip on each iteration.
//   - Sequences one WIDTH-bit multiply per start request.
//   - Reports busy/done to the top-level handshake.
//

---
 rtl/shift_add_mult_ctrl.sv | 116 +++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_add_mult_ctrl                                              |
// | Purpose  : Control unit for a sequential shift-and-add multiplier. Loads    |
// |            the operand registers, then runs WIDTH add/shift iterations,     |
// |            adding A into P whenever the current multiplier bit is set.      |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module shift_add_mult_ctrl #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             lsb_in,
  output logic             ld_a,
  output logic             ld_b,
  output logic             clr_p,
  output logic             ld_p,
  output logic             shr_en_b,
  output logic             shr_en_p,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_iter_cnt;

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Iteration counter: cleared on load, bumped per shift, cleared again when leaving DONE
  // so that IDLE always presents an all-zero output vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iter_cnt <= '0;
    end else begin
      case (r_state)
        LOAD:    r_iter_cnt <= '0;
        SHIFT:   r_iter_cnt <= r_iter_cnt + c_cnt_one;
        DONE:    r_iter_cnt <= '0;
        default: r_iter_cnt <= r_iter_cnt;
      endcase
    end
  end

  // Next-state and state-decoded outputs; ld_p is the only output that looks at an input.
  always_comb begin
    w_next_state = r_state;
    ld_a         = 1'b0;
    ld_b         = 1'b0;
    clr_p        = 1'b0;
    ld_p         = 1'b0;
    shr_en_b     = 1'b0;
    shr_en_p     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = LOAD;
        end
      end
      LOAD: begin
        ld_a         = 1'b1;
        ld_b         = 1'b1;
        clr_p        = 1'b1;
        busy         = 1'b1;
        w_next_state = ADD;
      end
      ADD: begin
        busy         = 1'b1;
        ld_p         = lsb_in;
        w_next_state = SHIFT;
      end
      SHIFT: begin
        busy         = 1'b1;
        shr_en_b     = 1'b1;
        shr_en_p     = 1'b1;
        w_next_state = (r_iter_cnt == c_last_iter) ? DONE : ADD;
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign iter_cnt = r_iter_cnt;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_shift_add_mult_ctrl                                           |
// | Purpose  : Scoreboard bench for shift_add_mult_ctrl at WIDTH=16 and 4.      |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_shift_add_mult_ctrl;

  typedef struct {
    logic [15:0] b;
    int          lat;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start_s [2];
  logic       lsb_s   [2];
  logic       ld_a_o  [2];
  logic       ld_b_o  [2];
  logic       clr_p_o [2];
  logic       ld_p_o  [2];
  logic       shr_b_o [2];
  logic       shr_p_o [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic [4:0] cnt_o   [2];
  logic [4:0] cnt16;
  logic [2:0] cnt4;

  exp_t q0[$];
  exp_t q1[$];

  int checks   = 0;
  int failures = 0;

  shift_add_mult_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_s[0]), .lsb_in(lsb_s[0]),
    .ld_a(ld_a_o[0]), .ld_b(ld_b_o[0]), .clr_p(clr_p_o[0]), .ld_p(ld_p_o[0]),
    .shr_en_b(shr_b_o[0]), .shr_en_p(shr_p_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .iter_cnt(cnt16)
  );

  shift_add_mult_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_s[1]), .lsb_in(lsb_s[1]),
    .ld_a(ld_a_o[1]), .ld_b(ld_b_o[1]), .clr_p(clr_p_o[1]), .ld_p(ld_p_o[1]),
    .shr_en_b(shr_b_o[1]), .shr_en_p(shr_p_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .iter_cnt(cnt4)
  );

  always_comb begin
    cnt_o[0] = cnt16;
    cnt_o[1] = {2'b00, cnt4};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] outs(input int u);
    return {ld_a_o[u], ld_b_o[u], clr_p_o[u], ld_p_o[u], shr_b_o[u], shr_p_o[u],
            busy_o[u], done_o[u], cnt_o[u]};
  endfunction

  // ---------------- monitor / scoreboard consumer ----------------
  int          m_lat   [2];
  int          m_addi  [2];
  int          m_shr   [2];
  logic [15:0] m_pat   [2];
  bit          m_in_op [2];
  bit          m_pdone [2];
  int          m_w;
  bit          m_is_add;
  exp_t        m_e;

  always @(negedge clk) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        m_in_op[u] = 1'b0;
        m_pdone[u] = 1'b0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        m_w = (u == 0) ? 16 : 4;
        check("excl_ldp_shr", {31'b0, ld_p_o[u] & (shr_b_o[u] | shr_p_o[u])}, 32'd0);
        check("excl_load_dp", {31'b0, (ld_a_o[u] | ld_b_o[u]) & (ld_p_o[u] | shr_b_o[u] | shr_p_o[u])}, 32'd0);
        if (!busy_o[u]) check("idle_zero", {19'b0, outs(u)}, 32'd0);
        m_is_add = busy_o[u] & ~ld_a_o[u] & ~shr_b_o[u] & ~done_o[u];
        if (!m_is_add) check("ldp_outside_add", {31'b0, ld_p_o[u]}, 32'd0);
        if (ld_a_o[u]) begin
          m_in_op[u] = 1'b1;
          m_lat[u]   = 0;
          m_addi[u]  = 0;
          m_shr[u]   = 0;
          m_pat[u]   = '0;
        end else if (m_in_op[u]) begin
          m_lat[u]++;
        end
        if (m_is_add && m_in_op[u]) begin
          check("ldp_in_add", {31'b0, ld_p_o[u]}, {31'b0, lsb_s[u]});
          if (m_addi[u] < 16) m_pat[u][m_addi[u]] = ld_p_o[u];
          m_addi[u]++;
        end
        if (shr_b_o[u]) m_shr[u]++;
        if (m_pdone[u]) check("done_one_cycle", {31'b0, done_o[u]}, 32'd0);
        m_pdone[u] = done_o[u];
        if (done_o[u]) begin
          if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            if (u == 0) m_e = q0.pop_front();
            else        m_e = q1.pop_front();
            check("done_latency", m_lat[u], m_e.lat);
            check("ldp_pattern", {16'b0, m_pat[u]}, {16'b0, m_e.b});
            check("shift_pulses", m_shr[u], m_w);
            check("iter_cnt_done", {27'b0, cnt_o[u]}, m_w);
            check("busy_in_done", {31'b0, busy_o[u]}, 32'd1);
          end
          m_in_op[u] = 1'b0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Runs one multiply on unit u, feeding b's bits on lsb_in during each ADD.
  // noise toggles lsb_in outside ADD; extra pulses start while busy;
  // abort_j >= 0 asserts rst in that cycle (cycle index after the start edge).
  task automatic do_op(input int u, input logic [15:0] b, input bit noise,
                       input bit extra, input int abort_j);
    int   w;
    exp_t e;
    w = (u == 0) ? 16 : 4;
    start_s[u] = 1'b1;
    if (abort_j < 0) begin
      e.b   = b & 16'((32'd1 << w) - 1);
      e.lat = 2 * w + 1;
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk); #1;
    for (int j = 0; j <= 2 * w + 1; j++) begin
      if (j >= 1 && j <= 2 * w && j[0]) lsb_s[u] = b[(j - 1) / 2];
      else if (noise)                   lsb_s[u] = ~lsb_s[u];
      else                              lsb_s[u] = 1'b0;
      start_s[u] = extra && (j == 0 || j == 5 || j == 2 * w + 1);
      if (j == abort_j) begin
        check("pre_abort_cnt", {27'b0, cnt_o[u]}, (j - 2) / 2);
        rst = 1'b1;
        #1;
        check("rst_outputs", {19'b0, outs(u)}, 32'd0);
        check("rst_iter_cnt", {27'b0, cnt_o[u]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
          @(negedge clk);
          check("post_rst_idle", {30'b0, busy_o[u], done_o[u]}, 32'd0);
        end
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    start_s[u] = 1'b0;
    lsb_s[u]   = 1'b0;
  endtask

  int   nd;
  int   bl;
  int   dt [3];
  exp_t e0;

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0;
      lsb_s[u]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs16", {19'b0, outs(0)}, 32'd0);
    check("reset_outs4",  {19'b0, outs(1)}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(0, 16'h0005, 1'b0, 1'b0, -1);   // sparse multiplier, W=16
    do_op(1, 16'h000F, 1'b0, 1'b0, -1);   // all ones, W=4
    do_op(1, 16'h0006, 1'b0, 1'b0, -1);
    do_op(0, 16'h8001, 1'b0, 1'b1, -1);   // start pulses while busy
    repeat (3) begin
      @(negedge clk);
      check("idle_after_extra", {31'b0, busy_o[0]}, 32'd0);
    end
    @(posedge clk); #1;
    do_op(0, 16'hA5C3, 1'b1, 1'b0, -1);   // lsb_in noise outside ADD
    do_op(0, 16'h1234, 1'b0, 1'b0, 16);   // reset in SHIFT at iteration 7

    // start held high: three back-to-back multiplies
    e0.b   = 16'h0000;
    e0.lat = 33;
    repeat (3) q0.push_back(e0);
    start_s[0] = 1'b1;
    nd = 0;
    bl = 0;
    for (int k = 0; k < 3; k++) dt[k] = 0;
    for (int c = 0; c < 400 && nd < 3; c++) begin
      @(negedge clk);
      if (nd >= 1 && !busy_o[0]) bl++;
      if (done_o[0]) begin
        dt[nd] = c;
        nd++;
        if (nd == 3) start_s[0] = 1'b0;
      end
    end
    start_s[0] = 1'b0;
    check("b2b_done_count", nd, 3);
    check("b2b_spacing1", dt[1] - dt[0], 35);
    check("b2b_spacing2", dt[2] - dt[1], 35);
    check("b2b_busy_low", bl, 2);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
